// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter sharing one enable-gated latch bank among requesters.
// Each access runs setup -> enable window -> hold so D only moves while en=0.
module latch_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int EN_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        clr,
    input  logic [NUM_REQ*DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0]         lat_d,
    output logic                      lat_en,
    output logic                      lat_rst,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(EN_CYCLES + 1);
    localparam logic [CW-1:0] EN_LAST = CW'(EN_CYCLES - 1);
    localparam logic [IW-1:0] LAST_REQ = IW'(NUM_REQ - 1);
    localparam logic [IW:0] NUM_REQ_W = (IW+1)'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

    state_t state, next_state;
    logic [IW-1:0] ptr, win, win_inc, base, pick, idx;
    logic [IW:0] sum;
    logic [CW-1:0] cnt;
    logic cap_clr, found, go;

    logic [NUM_REQ-1:0] gnt_nx, ack_nx;
    logic [DATA_W-1:0] d_nx;
    logic en_nx, rst_nx;

    assign win_inc = (win == LAST_REQ) ? '0 : win + 1'b1;

    // Search starts at the pointer, or just past the finishing winner in HOLD
    // so a waiting requester is granted back-to-back with no idle cycle.
    always_comb begin
        base  = (state == HOLD) ? win_inc : ptr;
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, base} + (IW+1)'(i);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign go = found && (state == IDLE || state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    next_state = go ? SETUP : IDLE;
            SETUP:   next_state = ENABLE;
            ENABLE:  next_state = (cnt == EN_LAST) ? HOLD : ENABLE;
            HOLD:    next_state = go ? SETUP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        gnt_nx = gnt;
        d_nx   = lat_d;
        ack_nx = '0;
        if (go) begin
            gnt_nx       = '0;
            gnt_nx[pick] = 1'b1;
            d_nx = clr[pick] ? '0 : wr_data[pick*DATA_W +: DATA_W];
        end else if (state == HOLD) begin
            gnt_nx = '0;
        end
        en_nx  = (next_state == ENABLE);
        rst_nx = en_nx && cap_clr;
        if (next_state == HOLD) begin
            ack_nx[win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_d   <= '0;
            lat_en  <= 1'b0;
            lat_rst <= 1'b0;
            gnt     <= '0;
            ack     <= '0;
            ptr     <= '0;
            win     <= '0;
            cap_clr <= 1'b0;
            cnt     <= '0;
        end else begin
            lat_d   <= d_nx;
            lat_en  <= en_nx;
            lat_rst <= rst_nx;
            gnt     <= gnt_nx;
            ack     <= ack_nx;
            if (state == HOLD) begin
                ptr <= win_inc;
            end
            if (go) begin
                win     <= pick;
                cap_clr <= clr[pick];
            end
            cnt <= (state == ENABLE) ? cnt + 1'b1 : '0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: directed vector table, corner sequences and
// random traffic against a cycle-timeline reference model.
module tb_latch_write_arbiter;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int EN  = 2;
    localparam int LEN = EN + 2;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0] req, clr, gnt, ack;
    logic [N*W-1:0] wr_data;
    logic [W-1:0] lat_d, q;
    logic lat_en, lat_rst, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    latch_write_arbiter #(
        .NUM_REQ(N), .DATA_W(W), .EN_CYCLES(EN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .clr(clr),
        .wr_data(wr_data), .lat_d(lat_d), .lat_en(lat_en),
        .lat_rst(lat_rst), .gnt(gnt), .ack(ack), .busy(busy)
    );

    typedef struct {
        logic         rn;
        logic [N-1:0] req;
        logic [N-1:0] clr;
        logic [N*W-1:0] data;
        logic [N-1:0] gnt;
        logic [N-1:0] ack;
        logic [W-1:0] d;
        logic         en;
        logic         rs;
        logic         busy;
        logic         chk_q;
        logic [W-1:0] q;
    } vec_t;

    vec_t tbl[16];

    // model state: t = cycle within current access (0 = idle)
    int t, mptr, mwin;
    logic mclr;
    logic [W-1:0] mcd, md;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // external latch model, driven from what the arbiter presents
    task automatic step();
        @(negedge clk);
        if (lat_en) q = lat_rst ? '0 : lat_d;
    endtask

    task automatic model_advance();
        int j;
        if (t == 0 || t == LEN) begin
            if (t == LEN) mptr = (mwin + 1) % N;
            t = 0;
            if (req != '0) begin
                for (int k = 0; k < N; k++) begin
                    j = (mptr + k) % N;
                    if (t == 0 && req[j]) begin
                        mwin = j;
                        t = 1;
                    end
                end
                mclr = clr[mwin];
                mcd  = mclr ? '0 : wr_data[mwin*W +: W];
                md   = mcd;
            end
        end else begin
            t++;
        end
    endtask

    function automatic logic [31:0] model_obs();
        logic [N-1:0] g, a;
        logic e;
        g = '0;
        a = '0;
        if (t != 0) g[mwin] = 1'b1;
        if (t == LEN) a[mwin] = 1'b1;
        e = (t >= 2 && t <= LEN - 1);
        return 32'({g, a, md, e, e && mclr, t != 0});
    endfunction

    initial begin
        int nack, last;
        logic [N-1:0] exp_ack, acc;

        rst_n = 1'b0;
        req = '0;
        clr = '0;
        wr_data = '0;
        q = '0;

        tbl[0]  = '{1'b0, 4'hF, 4'hF, 32'h12345678, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 4'h1, 4'h0, 32'h000000A5, 4'h1, 4'h0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 4'h0, 4'h0, 32'h00000000, 4'h1, 4'h0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 4'h0, 4'h0, 32'h00000000, 4'h1, 4'h0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 4'h0, 4'h0, 32'h00000000, 4'h1, 4'h1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
        tbl[5]  = '{1'b1, 4'h0, 4'h0, 32'h00000000, 4'h0, 4'h0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[6]  = '{1'b1, 4'h2, 4'h2, 32'h00005A00, 4'h2, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[7]  = '{1'b1, 4'h0, 4'h0, 32'h00000000, 4'h2, 4'h0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[8]  = '{1'b1, 4'h0, 4'h0, 32'h00000000, 4'h2, 4'h0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[9]  = '{1'b1, 4'h0, 4'h0, 32'h00000000, 4'h2, 4'h2, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[10] = '{1'b1, 4'h0, 4'h0, 32'h00000000, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[11] = '{1'b1, 4'h1, 4'h0, 32'h0000003C, 4'h1, 4'h0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[12] = '{1'b1, 4'h0, 4'h0, 32'h000000C3, 4'h1, 4'h0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[13] = '{1'b1, 4'h0, 4'h0, 32'h000000C3, 4'h1, 4'h0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[14] = '{1'b1, 4'h0, 4'h0, 32'h000000C3, 4'h1, 4'h1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C};
        tbl[15] = '{1'b1, 4'h0, 4'h0, 32'h000000C3, 4'h0, 4'h0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        step();
        for (int i = 0; i < 16; i++) begin
            rst_n   = tbl[i].rn;
            req     = tbl[i].req;
            clr     = tbl[i].clr;
            wr_data = tbl[i].data;
            step();
            check($sformatf("vec%0d", i),
                  32'({gnt, ack, lat_d, lat_en, lat_rst, busy}),
                  32'({tbl[i].gnt, tbl[i].ack, tbl[i].d, tbl[i].en,
                       tbl[i].rs, tbl[i].busy}));
            if (tbl[i].chk_q) check($sformatf("vec%0d_q", i), 32'(q), 32'(tbl[i].q));
        end

        // contention: all four held, pointer freshly reset
        rst_n = 1'b0;
        req = '0;
        clr = '0;
        step();
        rst_n = 1'b1;
        req = '1;
        wr_data = 32'h44332211;
        nack = 0;
        last = 0;
        for (int c = 1; c <= 40 && nack < 5; c++) begin
            step();
            if (ack != '0) begin
                exp_ack = '0;
                exp_ack[nack % N] = 1'b1;
                check("cont_ack", 32'(ack), 32'(exp_ack));
                if (nack == 0) check("cont_latency", c, LEN);
                else check("cont_gap", c - last, LEN);
                last = c;
                nack++;
            end
        end
        check("cont_count", nack, 5);
        req = '0;
        step();
        check("cont_idle", 32'(busy), 0);

        // reset in the middle of the enable window
        req = 4'b0010;
        step();
        req = '0;
        step();
        check("rst_pre_en", 32'(lat_en), 1);
        #2 rst_n = 1'b0;
        #1 check("rst_async", 32'({gnt, ack, lat_en, lat_rst, busy}), 0);
        step();
        rst_n = 1'b1;
        acc = '0;
        for (int k = 0; k < 6; k++) begin
            step();
            acc |= ack;
        end
        check("rst_no_ack", 32'(acc), 0);
        req = 4'b0101;
        step();
        check("rst_ptr_gnt", 32'(gnt), 32'h1);
        req = '0;
        for (int k = 0; k < 5; k++) step();

        // random traffic against the reference model
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        t = 0;
        mptr = 0;
        mwin = 0;
        mclr = 1'b0;
        mcd = '0;
        md = '0;
        for (int k = 0; k < 600; k++) begin
            req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            clr = N'($urandom) & N'($urandom);
            wr_data = $urandom;
            step();
            model_advance();
            check("rand_obs", 32'({gnt, ack, lat_d, lat_en, lat_rst, busy}),
                  model_obs());
            if (ack != '0) check("rand_q", 32'(q), 32'(mcd));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
